pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 71, payload width per entry (two 32-bit words, 5-bit destination, 2 control bits).
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
REQ-005 Port flush  input  1  synchronous discard of all held entries.
REQ-006 Port in_valid  input  1  upstream presents a payload.
REQ-007 Port in_data  input  DATA_W  upstream payload.
REQ-008 Port in_ready  output  1  block accepts a payload this cycle; driven directly from a flop.
REQ-009 Port out_valid  output  1  out_data holds a valid payload.
REQ-010 Port out_data  output  DATA_W  downstream payload; driven directly from the main-entry flops.
REQ-011 Port out_ready  input  1  downstream consumes the payload this cycle.
REQ-012 Port occupancy  output  2  number of held entries, 0 to 2.
REQ-013 Port stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-014 The block SHALL hold two entries: main (drives out_*) and skid (overflow).
REQ-015 State machine SHALL have three states: EMPTY (0 held), ONE (main only), TWO (main and skid).
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-017 EMPTY: on transfer in, load main and go to ONE.
REQ-018 ONE: transfer in only -> load skid, go to TWO; transfer out only -> go to EMPTY; both -> load main, stay in ONE; neither -> hold.
REQ-019 TWO: in_ready SHALL be 0; on transfer out, move skid to main and go to ONE; otherwise hold.
REQ-020 in_ready SHALL be 1 exactly when state is not TWO, computed from registered state only (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 exactly when state is ONE or TWO; occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO.
REQ-022 Latency SHALL be one cycle: a payload accepted at edge N is visible on out_data after edge N when main was empty or being drained that cycle.
REQ-023 Ordering SHALL be strict FIFO; no payload is dropped or duplicated except by flush or reset.
REQ-024 Flush SHALL take priority over all transfers: next state EMPTY, and any in_valid in the same cycle is discarded.
REQ-025 A transfer out in a flush cycle SHALL still count as consumed downstream; data flops need not be cleared by flush.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready and !flush, and SHALL saturate at 2^CNT_W-1.
REQ-027 stall_cnt SHALL be cleared by reset only, never by flush.

Reset
REQ-028 While reset=0: state EMPTY, in_ready=1, out_valid=0, occupancy=0, stall_cnt=0, out_data=0, skid data=0.
REQ-029 Reset asserted mid-operation SHALL discard both entries without waiting for a clock edge.
REQ-030 After reset deasserts, the first transfer in SHALL be accepted on the first rising edge.

Structure
REQ-031 State encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default DATA_W/CNT_W SHALL live in the shared pipeline package.
REQ-032 Each entry SHALL be one instance of sub-module pipe_data_reg (DATA_W-wide enabled register with async active-low clear), instantiated twice.
REQ-033 Control FSM and stall counter SHALL reside in pipe_skid_reg itself.

Verification
REQ-034 Reset then in_valid=1 with data 0x1..0x5 on consecutive cycles, out_ready=1 -> out_data 0x1..0x5 one cycle later each, occupancy never >1, stall_cnt=0.
REQ-035 out_ready=0 while 0xA, 0xB are pushed -> occupancy=2, in_ready=0, 0xC is held upstream; out_ready=1 -> 0xA, 0xB, 0xC in order.
REQ-036 Hold TWO with out_ready=0 for 10 cycles -> stall_cnt=10; with CNT_W=4 and 20 cycles -> stall_cnt=15.
REQ-037 In TWO, flush=1 with in_valid=1 and data 0xF -> next cycle EMPTY, out_valid=0, 0xF never appears, stall_cnt unchanged.
REQ-038 Reset=0 pulsed between edges while in ONE -> out_valid=0 and occupancy=0 immediately, before the next edge.
REQ-039 Random in_valid/out_ready at 50% for 10k cycles -> scoreboard shows exact FIFO order and in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: default widths, skid-stage state encoding and payload layout.
package pipe_skid_reg_pkg;

  localparam int unsigned PIPE_DATA_W = 71;
  localparam int unsigned PIPE_CNT_W  = 16;
  localparam int unsigned PIPE_OCC_W  = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Default payload layout carried through the stage (71 bits).
  typedef struct packed {
    logic [31:0] word_hi;
    logic [31:0] word_lo;
    logic [4:0]  dest;
    logic [1:0]  ctrl;
  } pipe_payload_t;

endpackage

// File: rtl/pipe_skid_reg_data.sv
// One payload entry: enabled register with asynchronous active-low clear.
module pipe_data_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: registered in_ready, one-cycle latency, FIFO order,
// synchronous flush and a saturating backpressure counter.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CNT_W  = PIPE_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [PIPE_OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_state_e             state_q;
  pipe_state_e             state_d;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [PIPE_OCC_W-1:0]   occ_q;
  logic [CNT_W-1:0]        stall_q;

  logic                    xfer_in_c;
  logic                    xfer_out_c;
  logic                    load_main_c;
  logic                    load_skid_c;
  logic                    main_from_skid_c;
  logic [DATA_W-1:0]       main_d_c;
  logic [DATA_W-1:0]       main_q;
  logic [DATA_W-1:0]       skid_q;

  assign xfer_in_c  = in_valid & in_ready_q;
  assign xfer_out_c = out_valid_q & out_ready;

  // State register; handshake/status outputs are re-registered from next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      occ_q       <= PIPE_OCC_W'(state_d);
    end
  end

  // Next-state and entry load control; flush overrides every transfer.
  always_comb begin
    state_d          = state_q;
    load_main_c      = 1'b0;
    load_skid_c      = 1'b0;
    main_from_skid_c = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_in_c) begin
            load_main_c = 1'b1;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({xfer_in_c, xfer_out_c})
            2'b10: begin
              load_skid_c = 1'b1;
              state_d     = ST_TWO;
            end
            2'b01: begin
              state_d = ST_EMPTY;
            end
            2'b11: begin
              load_main_c = 1'b1;
            end
            default: begin
            end
          endcase
        end
        ST_TWO: begin
          if (xfer_out_c) begin
            load_main_c      = 1'b1;
            main_from_skid_c = 1'b1;
            state_d          = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign main_d_c = main_from_skid_c ? skid_q : in_data;

  // Backpressure counter survives flush; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && !flush && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  pipe_data_reg #(
    .DATA_W (DATA_W)
  ) u_main (
    .clk   (clock),
    .rst_n (reset),
    .en    (load_main_c),
    .d     (main_d_c),
    .q     (main_q)
  );

  pipe_data_reg #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk   (clock),
    .rst_n (reset),
    .en    (load_skid_c),
    .d     (in_data),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_pipe_skid_reg;
  import pipe_skid_reg_pkg::*;

  localparam int unsigned DW = PIPE_DATA_W;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready,  in_ready4;
  logic          out_valid, out_valid4;
  logic [DW-1:0] out_data,  out_data4;
  logic [1:0]    occupancy, occupancy4;
  logic [15:0]   stall_cnt;
  logic [3:0]    stall_cnt4;

  pipe_skid_reg dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_ready (out_ready),
    .occupancy (occupancy4),
    .stall_cnt (stall_cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: held entries in arrival order, plus an unbounded stall tally.
  logic [DW-1:0] mq[$];
  int unsigned   ms;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [1:0]    e_occ;
    logic [DW-1:0] e_d;
    int unsigned   e_stall;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic iv, input int unsigned d, input logic ordy,
                              input logic eir, input logic eov, input logic [1:0] eocc,
                              input int unsigned ed, input int unsigned es);
    vec_t v;
    v.iv = iv; v.d = DW'(d); v.ordy = ordy;
    v.e_ir = eir; v.e_ov = eov; v.e_occ = eocc; v.e_d = DW'(ed); v.e_stall = es;
    return v;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    int sz = mq.size();
    if (flush) begin
      mq.delete();
    end else begin
      if (sz > 0 && !out_ready) ms++;
      if (sz > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && sz < 2) mq.push_back(in_data);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    int sz = mq.size();
    chk({tag, ".in_ready"},   128'(in_ready),   128'(sz < 2));
    chk({tag, ".out_valid"},  128'(out_valid),  128'(sz > 0));
    chk({tag, ".occupancy"},  128'(occupancy),  128'(sz));
    chk({tag, ".stall"},      128'(stall_cnt),  128'(sat(ms, 65535)));
    chk({tag, ".occ4"},       128'(occupancy4), 128'(sz));
    chk({tag, ".stall4"},     128'(stall_cnt4), 128'(sat(ms, 15)));
    if (sz > 0) begin
      chk({tag, ".out_data"},  128'(out_data),  128'(mq[0]));
      chk({tag, ".out_data4"}, 128'(out_data4), 128'(mq[0]));
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ms = 0;
  endtask

  initial begin
    logic [95:0]   r;
    int unsigned   base;
    logic [15:0]   stall_hold;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst.in_ready",  128'(in_ready),  128'(1));
    chk("rst.out_valid", 128'(out_valid), 128'(0));
    chk("rst.occupancy", 128'(occupancy), 128'(0));
    chk("rst.stall",     128'(stall_cnt), 128'(0));
    chk("rst.out_data",  128'(out_data),  128'(0));
    reset = 1'b1;

    // Streaming 1..5 with a ready sink, then A,B,C under backpressure.
    for (int i = 0; i < 5; i++) vecs[i] = mk(1'b1, i + 1, 1'b1, 1'b1, 1'b1, 2'd1, i + 1, 0);
    vecs[5]  = mk(1'b0, 0,    1'b1, 1'b1, 1'b0, 2'd0, 0,    0);
    vecs[6]  = mk(1'b1, 'hA,  1'b0, 1'b1, 1'b1, 2'd1, 'hA,  0);
    vecs[7]  = mk(1'b1, 'hB,  1'b0, 1'b0, 1'b1, 2'd2, 'hA,  1);
    vecs[8]  = mk(1'b1, 'hC,  1'b0, 1'b0, 1'b1, 2'd2, 'hA,  2);
    vecs[9]  = mk(1'b1, 'hC,  1'b1, 1'b1, 1'b1, 2'd1, 'hB,  2);
    vecs[10] = mk(1'b1, 'hC,  1'b1, 1'b1, 1'b1, 2'd1, 'hC,  2);
    vecs[11] = mk(1'b0, 0,    1'b1, 1'b1, 1'b0, 2'd0, 0,    2);

    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      tick();
      chk($sformatf("vec%0d.in_ready", i),  128'(in_ready),   128'(vecs[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 128'(out_valid),  128'(vecs[i].e_ov));
      chk($sformatf("vec%0d.occupancy", i), 128'(occupancy),  128'(vecs[i].e_occ));
      chk($sformatf("vec%0d.stall", i),     128'(stall_cnt),  128'(vecs[i].e_stall));
      chk($sformatf("vec%0d.stall4", i),    128'(stall_cnt4), 128'(vecs[i].e_stall));
      if (vecs[i].e_ov)
        chk($sformatf("vec%0d.out_data", i), 128'(out_data), 128'(vecs[i].e_d));
    end

    // Stall counting in TWO, including saturation of the narrow counter.
    reset = 1'b0;
    #1;
    model_reset();
    reset = 1'b1;
    in_valid = 1'b1; in_data = DW'('h11); out_ready = 1'b0;
    tick();
    in_data = DW'('h22);
    tick();
    in_valid = 1'b0;
    check_all("fill");
    base = ms;
    repeat (10) tick();
    check_all("hold10");
    chk("hold10.delta", 128'(stall_cnt), 128'(base + 10));
    repeat (10) tick();
    check_all("hold20");
    chk("hold20.sat4", 128'(stall_cnt4), 128'(15));

    // Flush in TWO discards the queued pair and the concurrent push.
    stall_hold = stall_cnt;
    flush = 1'b1; in_valid = 1'b1; in_data = DW'('hF); out_ready = 1'b0;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_all("flush");
    chk("flush.out_valid", 128'(out_valid), 128'(0));
    chk("flush.stall_kept", 128'(stall_cnt), 128'(stall_hold));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("postflush%0d.out_valid", i), 128'(out_valid), 128'(0));
    end

    // Asynchronous reset while one entry is held, then immediate reuse.
    in_valid = 1'b1; in_data = DW'('h55); out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_all("preasync");
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("async.out_valid", 128'(out_valid), 128'(0));
    chk("async.occupancy", 128'(occupancy), 128'(0));
    chk("async.in_ready",  128'(in_ready),  128'(1));
    chk("async.out_data",  128'(out_data),  128'(0));
    #1 reset = 1'b1;
    in_valid = 1'b1; in_data = DW'('h77); out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_all("firstxfer");
    chk("firstxfer.out_data", 128'(out_data), 128'('h77));

    // Randomized traffic against the model, probing in_ready for out_ready leakage.
    for (int n = 0; n < 10000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 99) == 0);
      r = {$urandom(), $urandom(), $urandom()};
      in_data = r[DW-1:0];
      out_ready = ~out_ready;
      #1;
      chk("rand.in_ready_comb", 128'(in_ready), 128'(mq.size() < 2));
      out_ready = ~out_ready;
      #1;
      tick();
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
